// File: rtl/lot_occupancy.sv
// Parking-lot gate decoder: synchronizes the two beam sensors, tracks enter/exit
// sequences and keeps a saturating car count with one-cycle event strobes.
module lot_occupancy #(
  parameter int CAPACITY = 3,
  parameter int CW       = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sensor_a,
  input  logic          sensor_b,
  output logic [CW-1:0] cars,
  output logic          enter_pulse,
  output logic          exit_pulse,
  output logic          err_pulse
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, AMBIG
  } state_t;

  state_t        state_q, state_d;
  logic          a_meta_q, a_meta_d, a_sync_q, a_sync_d;
  logic          b_meta_q, b_meta_d, b_sync_q, b_sync_d;
  logic [1:0]    ab;
  logic          enter_evt, exit_evt;
  logic [CW-1:0] cars_q, cars_d;
  logic          enter_q, enter_d, exit_q, exit_d, err_q, err_d;

  always_comb begin
    a_meta_d = sensor_a;
    b_meta_d = sensor_b;
    a_sync_d = a_meta_q;
    b_sync_d = b_meta_q;
  end

  assign ab = {a_sync_q, b_sync_q};

  always_comb begin
    state_d   = state_q;
    enter_evt = 1'b0;
    exit_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = ENT1;
          2'b01:   state_d = EXT1;
          2'b11:   state_d = AMBIG;
          default: state_d = IDLE;
        endcase
      end
      ENT1: begin
        case (ab)
          2'b11:   state_d = ENT2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = AMBIG;
          default: state_d = ENT1;
        endcase
      end
      ENT2: begin
        case (ab)
          2'b01:   state_d = ENT3;
          2'b10:   state_d = ENT1;
          2'b00:   state_d = AMBIG;
          default: state_d = ENT2;
        endcase
      end
      ENT3: begin
        case (ab)
          2'b00: begin
            state_d   = IDLE;
            enter_evt = 1'b1;
          end
          2'b11:   state_d = ENT2;
          2'b10:   state_d = AMBIG;
          default: state_d = ENT3;
        endcase
      end
      EXT1: begin
        case (ab)
          2'b11:   state_d = EXT2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = AMBIG;
          default: state_d = EXT1;
        endcase
      end
      EXT2: begin
        case (ab)
          2'b10:   state_d = EXT3;
          2'b01:   state_d = EXT1;
          2'b00:   state_d = AMBIG;
          default: state_d = EXT2;
        endcase
      end
      EXT3: begin
        case (ab)
          2'b00: begin
            state_d  = IDLE;
            exit_evt = 1'b1;
          end
          2'b11:   state_d = EXT2;
          2'b01:   state_d = AMBIG;
          default: state_d = EXT3;
        endcase
      end
      AMBIG: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Error strobes only on the edge that enters AMBIG, or on a saturated count.
  always_comb begin
    cars_d  = cars_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = (state_d == AMBIG) && (state_q != AMBIG);
    if (enter_evt) begin
      if (cars_q < CAP) begin
        cars_d  = cars_q + 1'b1;
        enter_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (exit_evt) begin
      if (cars_q != '0) begin
        cars_d = cars_q - 1'b1;
        exit_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      state_q  <= IDLE;
      cars_q   <= '0;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_meta_q <= a_meta_d;
      a_sync_q <= a_sync_d;
      b_meta_q <= b_meta_d;
      b_sync_q <= b_sync_d;
      state_q  <= state_d;
      cars_q   <= cars_d;
      enter_q  <= enter_d;
      exit_q   <= exit_d;
      err_q    <= err_d;
    end
  end

  assign cars        = cars_q;
  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign err_pulse   = err_q;

endmodule

// File: doc/lot_occupancy.md
Name: lot_occupancy

Overview:
- Upstream stage of the lot-spots HEX display block.
- Watches two gate photo-sensors: A is the outer beam, B is the inner beam.
- Decodes complete car-enter and car-exit sequences with a state machine.
- Keeps a saturating occupancy count and drives it on `cars` as the display block's car-count input.

Parameters:
- CAPACITY, 3, maximum cars in lot; must satisfy CAPACITY <= 2**CW-1.
- CW, 2, width of the `cars` count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sensor_a  input  1  outer beam broken (1 = blocked); asynchronous to clk.
- sensor_b  input  1  inner beam broken (1 = blocked); asynchronous to clk.
- cars  output  CW  current occupancy, 0..CAPACITY.
- enter_pulse  output  1  one-cycle strobe: a car was counted in.
- exit_pulse  output  1  one-cycle strobe: a car was counted out.
- err_pulse  output  1  one-cycle strobe: overflow, underflow, or entry into AMBIG.

Behaviour:
- Reset (reset_n=0, async), held until release:
  - `cars`, all pulses, and both synchronizer stages go to 0.
  - State goes to IDLE.
  - Reset mid-sequence discards the partial sequence.
- Synchronizer:
  - sensor_a and sensor_b each pass through 2 flops; FSM input is ab = {a_sync, b_sync}.
  - Raw change meeting setup is visible to the FSM after 2 edges.
- State transitions, by ab (unlisted values hold state):
  - IDLE: 10->ENT1, 01->EXT1, 11->AMBIG.
  - ENT1: 11->ENT2, 00->IDLE (abort, no count), 01->AMBIG.
  - ENT2: 01->ENT3, 10->ENT1 (backing out), 00->AMBIG.
  - ENT3: 00->IDLE with enter event, 11->ENT2, 10->AMBIG.
  - EXT1: 11->EXT2, 00->IDLE (abort), 10->AMBIG.
  - EXT2: 10->EXT3, 01->EXT1, 00->AMBIG.
  - EXT3: 00->IDLE with exit event, 11->EXT2, 01->AMBIG.
  - AMBIG: 00->IDLE; any other ab holds.
- Event handling (registered):
  - `cars` and the strobes update on the same edge as the event transition.
  - Raw sensor release to count change: 3 rising edges.
  - Enter event with cars<CAPACITY: cars+1, enter_pulse=1.
  - Enter event with cars==CAPACITY: cars held, err_pulse=1, enter_pulse=0.
  - Exit event with cars>0: cars-1, exit_pulse=1.
  - Exit event with cars==0: cars held at 0, err_pulse=1, exit_pulse=0.
  - Any transition into AMBIG: err_pulse=1 for that single cycle only.
- Exclusivity:
  - Only one event is possible per cycle, so enter and exit never coincide.
  - At most one of the three strobes is high in any cycle.
  - Each strobe is exactly one cycle wide.
- `cars` never leaves 0..CAPACITY; there is no wrap-around.
- A car sitting under the sensors at reset release is tracked from its synchronized state:
  - Half-way in (10 or 01) proceeds normally.
  - 11 goes to AMBIG with an err_pulse.
- Pedestrian-style patterns count nothing: A-only then release, or B-only then release.

Test Plan:
- Reset with sensors 00; full enter 00->10->11->01->00, 4 cycles per step -> cars 0->1; enter_pulse high exactly 1 cycle, 3 edges after final release.
- Four full enters from 0 (CAPACITY=3) -> cars 1,2,3,3; fourth gives err_pulse=1, enter_pulse=0.
- From cars=2, full exit 00->01->11->10->00 -> cars=1 with exit_pulse; at cars=0 an exit -> cars stays 0, err_pulse=1.
- Backing out 00->10->11->10->00 and B-only 00->01->00 -> cars unchanged, no pulses, state IDLE.
- Illegal 00->11 -> err_pulse once; further 11/01/10 stays silent; 00 returns to IDLE; next full enter counts normally.
- cars=2 and state ENT3; assert reset_n low asynchronously mid-cycle -> cars=0, outputs 0 immediately; after release with sensors 00, no spurious count.
